fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the ARMv8 pipelined core.
- Holds the PC and drives the word address into the instruction ROM (6-bit addr, 32-bit q, index range 0..18, returns 0 beyond).
- Latches the returned instruction and its PC into the IF/ID pipeline register.
- Handles stall, flush, branch redirect, end-of-program halt and misaligned-target fault.

Parameters:
N, 64, PC and datapath width
RESET_PC, 0, PC value loaded on reset
LAST_INDEX, 18, highest valid ROM word index; fetching beyond it halts the stage

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
pc_src  in  1  redirect request from branch resolution
pc_branch  in  N  redirect target byte address
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  hazard unit: insert bubble into IF/ID
imem_addr  out  6  ROM word index, combinational = pc[7:2]
imem_q  in  32  ROM read data, combinational from imem_addr
instr_d  out  32  IF/ID instruction
pc_d  out  N  IF/ID PC of instr_d
valid_d  out  1  IF/ID contents are a real instruction
pc_f  out  N  current fetch PC
halted  out  1  state == HALT
fault  out  1  state == FAULT (sticky)
fetch_count  out  32  number of instructions latched with valid_d=1, saturating

Behaviour:
- Reset asserted (reset=0, any time, including mid-operation): pc_f=RESET_PC, instr_d=0, pc_d=0, valid_d=0, fetch_count=0, state=BOOT. Reset takes effect without waiting for a clock edge.
- States: BOOT, RUN, HALT, FAULT.
- BOOT:
  - Exactly one cycle after reset release.
  - IF/ID is loaded with a bubble (valid_d=0, instr_d=0).
  - pc_f holds.
  - Next state is RUN, regardless of stall/flush/pc_src. Inputs are ignored in BOOT.
- RUN, evaluated in priority order each cycle:
  1. pc_src=1 and pc_branch[1:0]!=0:
     - Next state FAULT, IF/ID loads a bubble, pc_f holds.
  2. pc_src=1 with an aligned target:
     - pc_f<=pc_branch; IF/ID loads a bubble (wrong-path drop).
     - Overrides stall and flush.
  3. Out of range: pc_f[N-1:8]!=0 or pc_f[7:2]>LAST_INDEX, and stall=0:
     - Next state HALT, IF/ID loads a bubble, pc_f holds.
  4. stall=1:
     - pc_f holds.
     - IF/ID holds, unless flush=1, in which case IF/ID loads a bubble.
  5. flush=1:
     - pc_f<=pc_f+4, IF/ID loads a bubble.
  6. Otherwise:
     - pc_f<=pc_f+4; instr_d<=imem_q; pc_d<=pc_f; valid_d<=1.
     - fetch_count increments; it saturates at 0xFFFFFFFF.
- HALT:
  - valid_d<=0; pc_f holds; stall and flush are ignored.
  - pc_src=1 with an aligned target: pc_f<=pc_branch, next state RUN.
  - pc_src=1 with a misaligned target: next state FAULT.
- FAULT:
  - valid_d<=0; pc_f holds; all inputs ignored.
  - Left only via reset.
- Latency:
  - imem_addr reflects pc_f in the same cycle.
  - The instruction at pc_f appears on instr_d after the next rising edge.
  - Redirect costs one bubble.
- Arithmetic: pc_f+4 is N-bit modulo; wrap-around is not special-cased because the out-of-range check triggers HALT first.
- Bubble means instr_d=0, pc_d=0, valid_d=0. fetch_count increments only on a valid latch.

Test Plan:
- Reset low for 2 cycles, then release → during reset all outputs 0; BOOT cycle gives valid_d=0, pc_f=0; next edge gives instr_d=0xf8000000, pc_d=0, valid_d=1, pc_f=4.
- Free-run 19 cycles from RUN → instr_d walks 0xf8000000 … 0xf803800f with pc_d 0..0x48. At pc_f=0x4C: halted=1, valid_d=0, pc_f stays 0x4C, fetch_count=19.
- stall=1 for 3 cycles at pc_f=0x8 → pc_f=0x8 and IF/ID unchanged throughout. stall+flush together → valid_d=0, pc_f=0x8. Release → instr_d=0xf8010002.
- pc_src=1, pc_branch=0x3C while stall=1 → next edge pc_f=0x3C, valid_d=0. Following edge instr_d=0xb400004e, pc_d=0x3C.
- pc_src=1, pc_branch=0x3E → fault=1, valid_d=0. Further pc_src/aligned targets are ignored. Reset clears fault.
- Mid-run reset pulse (asynchronous, between edges) at pc_f=0x20 → outputs clear immediately. After BOOT, fetch restarts at 0 with fetch_count=0. From HALT, pc_src=1 to 0x40 → RUN, instr_d=0xcb01000f next.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, addresses the instruction ROM and fills the IF/ID register.
// Handles stall, flush, branch redirect, end-of-program halt and the misaligned-target fault.
module fetch_stage #(
  parameter int             N          = 64,
  parameter logic [N-1:0]   RESET_PC   = '0,
  parameter int             LAST_INDEX = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pc_src,
  input  logic [N-1:0]  pc_branch,
  input  logic          stall,
  input  logic          flush,
  output logic [5:0]    imem_addr,
  input  logic [31:0]   imem_q,
  output logic [31:0]   instr_d,
  output logic [N-1:0]  pc_d,
  output logic          valid_d,
  output logic [N-1:0]  pc_f,
  output logic          halted,
  output logic          fault,
  output logic [31:0]   fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [5:0] LAST_WORD = 6'(LAST_INDEX);

  state_t      state, state_nxt;
  logic [N-1:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [N-1:0] pcd_nxt;
  logic        valid_nxt;
  logic [31:0] count_nxt;
  logic        bubble;
  logic        load;
  logic        misaligned;
  logic        out_of_range;
  logic [N-1:0] pc_plus4;

  assign imem_addr    = pc_f[7:2];
  assign halted       = (state == ST_HALT);
  assign fault        = (state == ST_FAULT);
  assign misaligned   = (pc_branch[1:0] != 2'b00);
  // Anything past the last ROM word (including PCs above the ROM window) ends the program.
  assign out_of_range = (pc_f[N-1:8] != '0) || (pc_f[7:2] > LAST_WORD);
  assign pc_plus4     = pc_f + N'(4);

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_f;
    bubble    = 1'b0;
    load      = 1'b0;

    unique case (state)
      ST_BOOT: begin
        bubble    = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (pc_src && misaligned) begin
          bubble    = 1'b1;
          state_nxt = ST_FAULT;
        end else if (pc_src) begin
          bubble = 1'b1;
          pc_nxt = pc_branch;
        end else if (out_of_range && !stall) begin
          bubble    = 1'b1;
          state_nxt = ST_HALT;
        end else if (stall) begin
          bubble = flush;
        end else if (flush) begin
          bubble = 1'b1;
          pc_nxt = pc_plus4;
        end else begin
          load   = 1'b1;
          pc_nxt = pc_plus4;
        end
      end
      ST_HALT: begin
        bubble = 1'b1;
        if (pc_src) begin
          if (misaligned) begin
            state_nxt = ST_FAULT;
          end else begin
            pc_nxt    = pc_branch;
            state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        bubble = 1'b1;
      end
    endcase
  end

  always_comb begin
    instr_nxt = instr_d;
    pcd_nxt   = pc_d;
    valid_nxt = valid_d;
    count_nxt = fetch_count;
    if (bubble) begin
      instr_nxt = '0;
      pcd_nxt   = '0;
      valid_nxt = 1'b0;
    end else if (load) begin
      instr_nxt = imem_q;
      pcd_nxt   = pc_f;
      valid_nxt = 1'b1;
      count_nxt = (fetch_count == '1) ? fetch_count : fetch_count + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_BOOT;
      pc_f        <= RESET_PC;
      instr_d     <= '0;
      pc_d        <= '0;
      valid_d     <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc_f        <= pc_nxt;
      instr_d     <= instr_nxt;
      pc_d        <= pcd_nxt;
      valid_d     <= valid_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes expected IF/ID state to a
// scoreboard queue as each step is driven; entries are popped and compared after the edge.
module tb_fetch_stage;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pc_src = 1'b0;
  logic [N-1:0]  pc_branch = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [5:0]    imem_addr;
  logic [31:0]   imem_q;
  logic [31:0]   instr_d;
  logic [N-1:0]  pc_d;
  logic          valid_d;
  logic [N-1:0]  pc_f;
  logic          halted;
  logic          fault;
  logic [31:0]   fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.N(N), .RESET_PC('0), .LAST_INDEX(18)) dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .pc_branch(pc_branch),
    .stall(stall), .flush(flush), .imem_addr(imem_addr), .imem_q(imem_q),
    .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d), .pc_f(pc_f),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Program ROM: 19 words, zero beyond the last index.
  function automatic logic [31:0] rom(input logic [5:0] a);
    logic [31:0] w;
    case (a)
      6'd15:   w = 32'hb400004e;
      6'd16:   w = 32'hcb01000f;
      6'd18:   w = 32'hf803800f;
      default: w = (a <= 6'd18) ? (32'hf8000000 | (32'(a) << 15) | 32'(a)) : 32'h0;
    endcase
    return w;
  endfunction

  always_comb imem_q = rom(imem_addr);

  typedef enum {M_BOOT, M_RUN, M_HALT, M_FAULT} mstate_t;

  typedef struct {
    logic [31:0]  instr;
    logic [N-1:0] pcd;
    logic         valid;
    logic [N-1:0] pcf;
    logic         halted;
    logic         fault;
    logic [31:0]  cnt;
  } exp_t;

  mstate_t      m_state;
  logic [N-1:0] m_pc;
  logic [31:0]  m_instr;
  logic [N-1:0] m_pcd;
  logic         m_valid;
  logic [31:0]  m_cnt;
  exp_t         sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = M_BOOT;
    m_pc    = '0;
    m_instr = '0;
    m_pcd   = '0;
    m_valid = 1'b0;
    m_cnt   = '0;
  endfunction

  function automatic void model_bubble();
    m_instr = '0;
    m_pcd   = '0;
    m_valid = 1'b0;
  endfunction

  function automatic void model_step(input logic src, input logic [N-1:0] br,
                                     input logic st, input logic fl);
    case (m_state)
      M_BOOT: begin
        model_bubble();
        m_state = M_RUN;
      end
      M_RUN: begin
        if (src && br[1:0] != 2'b00) begin
          model_bubble();
          m_state = M_FAULT;
        end else if (src) begin
          model_bubble();
          m_pc = br;
        end else if (((m_pc >> 8) != 0 || m_pc[7:2] > 6'd18) && !st) begin
          model_bubble();
          m_state = M_HALT;
        end else if (st) begin
          if (fl) model_bubble();
        end else if (fl) begin
          model_bubble();
          m_pc = m_pc + 64'd4;
        end else begin
          m_instr = rom(m_pc[7:2]);
          m_pcd   = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 64'd4;
          if (m_cnt != 32'hffffffff) m_cnt = m_cnt + 32'd1;
        end
      end
      M_HALT: begin
        model_bubble();
        if (src) begin
          if (br[1:0] != 2'b00) begin
            m_state = M_FAULT;
          end else begin
            m_pc    = br;
            m_state = M_RUN;
          end
        end
      end
      default: model_bubble();
    endcase
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.instr  = m_instr;
    e.pcd    = m_pcd;
    e.valid  = m_valid;
    e.pcf    = m_pc;
    e.halted = (m_state == M_HALT);
    e.fault  = (m_state == M_FAULT);
    e.cnt    = m_cnt;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("instr_d", 64'(instr_d), 64'(e.instr));
    check("pc_d", pc_d, e.pcd);
    check("valid_d", 64'(valid_d), 64'(e.valid));
    check("pc_f", pc_f, e.pcf);
    check("halted", 64'(halted), 64'(e.halted));
    check("fault", 64'(fault), 64'(e.fault));
    check("fetch_count", 64'(fetch_count), 64'(e.cnt));
  endtask

  task automatic cycle(input logic src, input logic [N-1:0] br, input logic st, input logic fl);
    exp_t e;
    pc_src    = src;
    pc_branch = br;
    stall     = st;
    flush     = fl;
    check("imem_addr", 64'(imem_addr), 64'(m_pc[7:2]));
    model_step(src, br, st, fl);
    sb.push_back(snap());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(e);
    pc_src = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_instr_d"}, 64'(instr_d), 64'h0);
    check({tag, "_pc_d"}, pc_d, 64'h0);
    check({tag, "_valid_d"}, 64'(valid_d), 64'h0);
    check({tag, "_pc_f"}, pc_f, 64'h0);
    check({tag, "_fault"}, 64'(fault), 64'h0);
    check({tag, "_count"}, 64'(fetch_count), 64'h0);
  endtask

  initial begin
    model_reset();

    // Reset held low for two edges; everything stays cleared.
    #1;
    check_cleared("rst_t0");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_cleared("rst_hold");
    end
    reset = 1'b1;

    // BOOT bubble, then the first real fetch.
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("boot_valid", 64'(valid_d), 64'h0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("first_instr", 64'(instr_d), 64'hf8000000);
    check("first_pc_f", pc_f, 64'h4);

    // Free-run to the end of the program, then halt.
    repeat (18) cycle(1'b0, '0, 1'b0, 1'b0);
    check("last_instr", 64'(instr_d), 64'hf803800f);
    check("last_pc_d", pc_d, 64'h48);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("halt_flag", 64'(halted), 64'h1);
    check("halt_pc_f", pc_f, 64'h4c);
    check("halt_count", 64'(fetch_count), 64'd19);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("halt_ignores_stall", pc_f, 64'h4c);

    // Restart from HALT via redirect.
    cycle(1'b1, 64'h40, 1'b0, 1'b0);
    check("halt_resume", 64'(halted), 64'h0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("resume_instr", 64'(instr_d), 64'hcb01000f);

    // Reach pc_f=0x8 and exercise stall, stall+flush, release, flush.
    cycle(1'b1, 64'h0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    check("stall_pc_f", pc_f, 64'h8);
    check("stall_instr", 64'(instr_d), 64'hf8008001);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("stall_flush_valid", 64'(valid_d), 64'h0);
    check("stall_flush_pc_f", pc_f, 64'h8);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("release_instr", 64'(instr_d), 64'hf8010002);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("flush_pc_f", pc_f, 64'h10);

    // Redirect overrides stall; one bubble, then the target instruction.
    cycle(1'b1, 64'h3c, 1'b1, 1'b0);
    check("redir_pc_f", pc_f, 64'h3c);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("redir_instr", 64'(instr_d), 64'hb400004e);
    check("redir_pc_d", pc_d, 64'h3c);

    // Asynchronous reset between edges at pc_f=0x20.
    cycle(1'b1, 64'h1c, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("pre_reset_pc_f", pc_f, 64'h20);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_cleared("async_rst");
    #2;
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("restart_count", 64'(fetch_count), 64'h1);

    // Misaligned redirect faults; the fault is sticky until reset.
    cycle(1'b1, 64'h3e, 1'b0, 1'b0);
    check("fault_flag", 64'(fault), 64'h1);
    cycle(1'b1, 64'h10, 1'b0, 1'b0);
    check("fault_sticky_pc", pc_f, 64'h4);
    cycle(1'b0, '0, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_cleared("fault_rst");
    #2;
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("post_fault_instr", 64'(instr_d), 64'hf8000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
